overlay_display: RTL and testbench

OVERLAY_DISPLAY -- requirements
Module: overlay_display

---
 rtl/overlay_display.sv | 159 +++++++++++++++
 tb/tb_overlay_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/overlay_display.sv
// Bitmap overlay with reveal/blink sequencing over an external synchronous ROM.
// Pixel path: x,y at n -> rom_data at n+1 -> overlay_on/rgb registered at n+2.
module overlay_display #(
  parameter int          X0           = 140,
  parameter int          Y0           = 217,
  parameter int          W            = 359,
  parameter int          H            = 46,
  parameter int          SCALE_LOG2   = 0,
  parameter logic [11:0] KEY          = 12'h000,
  parameter int          REVEAL_STEP  = 2,
  parameter int          BLINK_FRAMES = 30,
  localparam int         ADDR_W       = $clog2(W * H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              frame_tick,
  input  logic              show,
  input  logic              hide,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              overlay_on,
  output logic [11:0]       rgb,
  output logic [1:0]        state_o
);

  localparam int X_END = X0 + (W << SCALE_LOG2);
  localparam int Y_END = Y0 + (H << SCALE_LOG2);
  // Wide enough for the pre-saturation sum of reveal_rows + REVEAL_STEP.
  localparam int RR_W  = $clog2(H + REVEAL_STEP + 1);
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2,
    BLINK  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [RR_W-1:0] reveal_rows_reg, reveal_rows_next;
  logic [BC_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic            blink_off_reg, blink_off_next;

  logic            win_d1_reg, vis_d1_reg;
  logic            overlay_on_reg;
  logic [11:0]     rgb_reg;

  logic            in_win;
  logic            visible;
  logic [9:0]      dx, dy, col, row;
  logic [RR_W-1:0] reveal_sum;

  always_comb begin
    in_win = (int'(x) >= X0) && (int'(x) < X_END) &&
             (int'(y) >= Y0) && (int'(y) < Y_END);
    dx     = x - 10'(X0);
    dy     = y - 10'(Y0);
    col    = dx >> SCALE_LOG2;
    row    = dy >> SCALE_LOG2;
    rom_addr = in_win ? (ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col)) : '0;
  end

  // Visibility is judged against the state seen at stage n and travels with the pixel.
  always_comb begin
    visible = 1'b0;
    case (state_reg)
      HIDDEN:  visible = 1'b0;
      REVEAL:  visible = (int'(row) < int'(reveal_rows_reg));
      SHOWN:   visible = 1'b1;
      BLINK:   visible = !blink_off_reg;
      default: visible = 1'b0;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    reveal_rows_next = reveal_rows_reg;
    blink_cnt_next   = blink_cnt_reg;
    blink_off_next   = blink_off_reg;
    reveal_sum       = reveal_rows_reg + RR_W'(REVEAL_STEP);
    if (hide) begin
      state_next       = HIDDEN;
      reveal_rows_next = '0;
      blink_cnt_next   = '0;
      blink_off_next   = 1'b0;
    end else begin
      case (state_reg)
        HIDDEN: begin
          if (show) begin
            state_next       = REVEAL;
            reveal_rows_next = '0;
          end
        end
        REVEAL: begin
          if (frame_tick) begin
            if (int'(reveal_sum) >= H) begin
              reveal_rows_next = RR_W'(H);
              state_next       = SHOWN;
            end else begin
              reveal_rows_next = reveal_sum;
            end
          end
        end
        SHOWN: begin
          if (frame_tick && blink_en) begin
            state_next     = BLINK;
            blink_cnt_next = '0;
            blink_off_next = 1'b0;
          end
        end
        BLINK: begin
          if (frame_tick) begin
            if (!blink_en) begin
              state_next     = SHOWN;
              blink_cnt_next = '0;
              blink_off_next = 1'b0;
            end else if (blink_cnt_reg == BC_W'(BLINK_FRAMES - 1)) begin
              blink_cnt_next = '0;
              blink_off_next = !blink_off_reg;
            end else begin
              blink_cnt_next = blink_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = HIDDEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= HIDDEN;
      reveal_rows_reg <= '0;
      blink_cnt_reg   <= '0;
      blink_off_reg   <= 1'b0;
      win_d1_reg      <= 1'b0;
      vis_d1_reg      <= 1'b0;
      overlay_on_reg  <= 1'b0;
      rgb_reg         <= 12'h000;
    end else begin
      state_reg       <= state_next;
      reveal_rows_reg <= reveal_rows_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_off_reg   <= blink_off_next;
      win_d1_reg      <= in_win;
      vis_d1_reg      <= visible;
      overlay_on_reg  <= win_d1_reg && vis_d1_reg && (rom_data != KEY);
      rgb_reg         <= (win_d1_reg && vis_d1_reg && (rom_data != KEY)) ? rom_data : 12'h000;
    end
  end

  assign overlay_on = overlay_on_reg;
  assign rgb        = rgb_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_overlay_display.sv
// Directed bench for overlay_display: a default instance plus a SCALE_LOG2=1 instance
// fed from small ROM models whose contents are {addr[10:0],1} unless forced to KEY.
module tb_overlay_display;

  logic        clk = 1'b0;
  logic        reset, frame_tick, show, hide, blink_en, force_key;
  logic [9:0]  x, y;
  logic [14:0] rom_addr, rom_addr2;
  logic [11:0] rom_data, rom_data2, rgb, rgb2;
  logic        overlay_on, overlay_on2;
  logic [1:0]  state_o, state_o2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  overlay_display dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
    .show(show), .hide(hide), .blink_en(blink_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .overlay_on(overlay_on), .rgb(rgb), .state_o(state_o)
  );

  overlay_display #(.SCALE_LOG2(1)) dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
    .show(show), .hide(hide), .blink_en(blink_en), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .overlay_on(overlay_on2), .rgb(rgb2), .state_o(state_o2)
  );

  always @(posedge clk) begin
    rom_data  <= force_key ? 12'h000 : {rom_addr[10:0], 1'b1};
    rom_data2 <= force_key ? 12'h000 : {rom_addr2[10:0], 1'b1};
  end

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse_show();
    @(negedge clk) show = 1'b1;
    @(negedge clk) show = 1'b0;
  endtask

  task automatic pulse_hide();
    @(negedge clk) hide = 1'b1;
    @(negedge clk) hide = 1'b0;
  endtask

  // Present one pixel, capture its ROM address, then its registered result two edges later.
  task automatic probe(input int px, input int py, output int a1, output int a2,
                       output int on1, output int c1, output int on2, output int c2);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    #1;
    a1 = int'(rom_addr);
    a2 = int'(rom_addr2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    on1 = int'(overlay_on);
    c1  = int'(rgb);
    on2 = int'(overlay_on2);
    c2  = int'(rgb2);
    $display("pixel (%0d,%0d) addr=%0d on=%0d rgb=%h | addr2=%0d on2=%0d rgb2=%h",
             px, py, a1, on1, c1, a2, on2, c2);
  endtask

  initial begin
    int a1, a2, on1, c1, on2, c2;
    reset = 1'b1; frame_tick = 1'b0; show = 1'b0; hide = 1'b0;
    blink_en = 1'b0; force_key = 1'b0;
    x = 10'd145; y = 10'd218;
    repeat (3) @(negedge clk);
    #1;
    check("addr_in_reset", int'(rom_addr), 364);
    check("rst_state", int'(state_o), 0);
    check("rst_on", int'(overlay_on), 0);
    check("rst_rgb", int'(rgb), 0);
    check("rst_rows", int'(dut.reveal_rows_reg), 0);
    @(negedge clk) reset = 1'b0;

    // show and hide together: hide wins
    @(negedge clk) begin show = 1'b1; hide = 1'b1; end
    @(negedge clk) begin show = 1'b0; hide = 1'b0; end
    check("show_hide_same", int'(state_o), 0);

    // show coincident with frame_tick: REVEAL with zero rows
    @(negedge clk) begin show = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin show = 1'b0; frame_tick = 1'b0; end
    $display("show+tick -> state=%0d rows=%0d", state_o, dut.reveal_rows_reg);
    check("show_tick_state", int'(state_o), 1);
    check("show_tick_rows", int'(dut.reveal_rows_reg), 0);
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("rows0_hidden", on1, 0);

    tick();
    check("rows_k1", int'(dut.reveal_rows_reg), 2);
    probe(140, 218, a1, a2, on1, c1, on2, c2);
    check("row1_on", on1, 1);
    check("row1_rgb", c1, 12'h2CF);
    probe(140, 219, a1, a2, on1, c1, on2, c2);
    check("row2_off", on1, 0);
    pulse_show();
    check("show_ignored_reveal", int'(state_o), 1);
    for (int k = 2; k <= 22; k++) begin
      tick();
      $display("tick %0d -> state=%0d rows=%0d", k, state_o, dut.reveal_rows_reg);
      check("reveal_rows", int'(dut.reveal_rows_reg), 2 * k);
      check("reveal_state", int'(state_o), 1);
    end
    tick();
    check("tick23_state", int'(state_o), 2);
    check("tick23_rows", int'(dut.reveal_rows_reg), 46);

    // window edges
    probe(139, 217, a1, a2, on1, c1, on2, c2);
    check("x139_addr", a1, 0);
    check("x139_on", on1, 0);
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("x140_on", on1, 1);
    check("x140_rgb", c1, 12'h001);
    probe(498, 217, a1, a2, on1, c1, on2, c2);
    check("x498_addr", a1, 358);
    check("x498_on", on1, 1);
    check("x498_rgb", c1, 12'h2CD);
    probe(499, 217, a1, a2, on1, c1, on2, c2);
    check("x499_addr", a1, 0);
    check("x499_on", on1, 0);
    probe(140, 263, a1, a2, on1, c1, on2, c2);
    check("y263_on", on1, 0);
    probe(140, 262, a1, a2, on1, c1, on2, c2);
    check("y262_addr", a1, 16155);
    check("y262_rgb", c1, 12'hE37);

    // 2x scaled instance
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("s_addr_140_217", a2, 0);
    probe(141, 218, a1, a2, on1, c1, on2, c2);
    check("s_addr_141_218", a2, 0);
    check("s_unscaled_141_218", a1, 360);
    probe(142, 217, a1, a2, on1, c1, on2, c2);
    check("s_addr_142_217", a2, 1);
    check("s_on", on2, 1);
    check("s_rgb", c2, 12'h003);
    force_key = 1'b1;
    probe(142, 217, a1, a2, on1, c1, on2, c2);
    check("s_key_on", on2, 0);
    check("s_key_rgb", c2, 0);
    force_key = 1'b0;

    // blinking
    blink_en = 1'b1;
    tick();
    check("blink_state", int'(state_o), 3);
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_vis0", on1, 1);
    repeat (29) tick();
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_vis29", on1, 1);
    tick();
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_off30", on1, 0);
    check("blink_off_rgb", c1, 0);
    repeat (29) tick();
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_off59", on1, 0);
    tick();
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_on60", on1, 1);
    repeat (30) tick();
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("blink_off90", on1, 0);
    blink_en = 1'b0;
    tick();
    check("unblink_state", int'(state_o), 2);
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("unblink_vis", on1, 1);

    // hide mid-reveal
    pulse_hide();
    check("hide_shown", int'(state_o), 0);
    pulse_show();
    repeat (3) tick();
    check("rev_rows6", int'(dut.reveal_rows_reg), 6);
    pulse_hide();
    check("hide_reveal_state", int'(state_o), 0);
    check("hide_reveal_rows", int'(dut.reveal_rows_reg), 0);

    // reset mid-blink with show and frame_tick asserted
    pulse_show();
    repeat (23) tick();
    blink_en = 1'b1;
    tick();
    check("pre_rst_blink", int'(state_o), 3);
    probe(140, 217, a1, a2, on1, c1, on2, c2);
    check("pre_rst_on", on1, 1);
    @(negedge clk) begin reset = 1'b1; show = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; show = 1'b0; frame_tick = 1'b0; end
    $display("reset in BLINK -> state=%0d on=%0d rgb=%h", state_o, overlay_on, rgb);
    check("rst_blink_state", int'(state_o), 0);
    check("rst_blink_on", int'(overlay_on), 0);
    check("rst_blink_rgb", int'(rgb), 0);
    check("rst_blink_cnt", int'(dut.blink_cnt_reg), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
